// File: rtl/boot_loader_ctrl_pkg.sv
// Shared definitions for the boot path: loader state encoding and the
// default bus widths used by the bios, instruction-memory and loader blocks.
package cpu_boot_pkg;

  localparam int BOOT_ADDR_W = 26;
  localparam int BOOT_DATA_W = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_WRITE,
    ST_DONE,
    ST_ERROR
  } boot_state_t;

  // States in which a start request launches a fresh copy.
  function automatic logic is_launch_state(input boot_state_t s);
    return (s == ST_IDLE) || (s == ST_DONE) || (s == ST_ERROR);
  endfunction

endpackage

// File: rtl/boot_loader_ctrl_if.sv
// Disk read port and instruction-memory write port seen by the boot loader.
import cpu_boot_pkg::*;

interface boot_loader_ctrl_if #(
  parameter int ADDR_W = BOOT_ADDR_W,
  parameter int DATA_W = BOOT_DATA_W
);

  logic              disk_rd_req;
  logic [ADDR_W-1:0] disk_addr;
  logic              disk_rd_ack;
  logic [DATA_W-1:0] disk_rd_data;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [DATA_W-1:0] imem_wdata;

  modport master (
    output disk_rd_req,
    output disk_addr,
    input  disk_rd_ack,
    input  disk_rd_data,
    output imem_we,
    output imem_addr,
    output imem_wdata
  );

  modport slave (
    input  disk_rd_req,
    input  disk_addr,
    output disk_rd_ack,
    output disk_rd_data,
    input  imem_we,
    input  imem_addr,
    input  imem_wdata
  );

endinterface

// File: rtl/boot_loader_ctrl_timeout_ctr.sv
// Loadable down-counter with synchronous clear; expired is high while the
// count sits at zero, so a load of N-1 expires on the N-th counted cycle.
import cpu_boot_pkg::*;

module boot_timeout_ctr #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec,
  output logic             expired
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - WIDTH'(1);
    end
  end

  assign expired = (count == '0);

endmodule

// File: rtl/boot_loader_ctrl.sv
// Copies PROG_WORDS words from disk into instruction memory at boot and
// hands CPU fetch from BIOS to instruction memory once the image is loaded.
import cpu_boot_pkg::*;

module boot_loader_ctrl #(
  parameter int ADDR_W     = BOOT_ADDR_W,
  parameter int DATA_W     = BOOT_DATA_W,
  parameter int PROG_WORDS = 100,
  parameter int DISK_BASE  = 0,
  parameter int TIMEOUT    = 255
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                start,
  boot_loader_ctrl_if.master  bus,
  output logic                bios_sel,
  output logic                busy,
  output logic                done,
  output logic                error
);

  localparam int CNT_W = $clog2(PROG_WORDS + 1);
  localparam int TMR_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PROG_WORDS - 1);
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT - 1);
  localparam logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(DISK_BASE);

  if (PROG_WORDS < 1) begin : g_bad_prog_words
    $error("boot_loader_ctrl: PROG_WORDS must be at least 1");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("boot_loader_ctrl: TIMEOUT must be at least 1");
  end

  boot_state_t      state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic             timer_clear;
  logic             timer_load;
  logic             timer_dec;
  logic             timer_expired;

  assign cnt_inc = cnt + CNT_W'(1);

  // The timer is reloaded every time WAIT is entered, so each word gets a
  // fresh TIMEOUT-cycle budget; an ack always wins over expiry.
  assign timer_load  = (start && is_launch_state(state)) ||
                       ((state == ST_WRITE) && (cnt != LAST_CNT));
  assign timer_clear = (state == ST_WAIT) && bus.disk_rd_ack;
  assign timer_dec   = (state == ST_WAIT) && !bus.disk_rd_ack;

  boot_timeout_ctr #(
    .WIDTH (TMR_W)
  ) u_timeout (
    .clock    (clock),
    .reset_n  (reset_n),
    .clear    (timer_clear),
    .load     (timer_load),
    .load_val (TMR_LOAD),
    .dec      (timer_dec),
    .expired  (timer_expired)
  );

  // Handshake outputs are set together with the state they belong to;
  // status flags are registered decodes of the current state, one cycle later.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state            <= ST_IDLE;
      cnt              <= '0;
      bus.disk_rd_req  <= 1'b0;
      bus.disk_addr    <= '0;
      bus.imem_we      <= 1'b0;
      bus.imem_addr    <= '0;
      bus.imem_wdata   <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      error            <= 1'b0;
      bios_sel         <= 1'b1;
    end else begin
      bus.imem_we <= 1'b0;
      busy        <= (state == ST_WAIT) || (state == ST_WRITE);
      done        <= (state == ST_DONE);
      error       <= (state == ST_ERROR);
      bios_sel    <= (state != ST_DONE);

      case (state)
        ST_IDLE, ST_DONE, ST_ERROR: begin
          if (start) begin
            cnt             <= '0;
            state           <= ST_WAIT;
            bus.disk_rd_req <= 1'b1;
            bus.disk_addr   <= BASE_ADDR;
          end
        end

        ST_WAIT: begin
          if (bus.disk_rd_ack) begin
            state           <= ST_WRITE;
            bus.disk_rd_req <= 1'b0;
            bus.imem_we     <= 1'b1;
            bus.imem_addr   <= ADDR_W'(cnt);
            bus.imem_wdata  <= bus.disk_rd_data;
          end else if (timer_expired) begin
            state           <= ST_ERROR;
            bus.disk_rd_req <= 1'b0;
          end
        end

        ST_WRITE: begin
          if (cnt == LAST_CNT) begin
            state <= ST_DONE;
          end else begin
            cnt             <= cnt_inc;
            state           <= ST_WAIT;
            bus.disk_rd_req <= 1'b1;
            bus.disk_addr   <= BASE_ADDR + ADDR_W'(cnt_inc);
          end
        end

        default: begin
          state           <= ST_IDLE;
          bus.disk_rd_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_boot_loader_ctrl.sv
// Scoreboard bench for boot_loader_ctrl: a disk responder with per-word ack
// delays, a monitor that pops expected writes/addresses, and a timing model.
`timescale 1ns/1ps

module tb_boot_loader_ctrl;

  localparam int ADDR_W     = 26;
  localparam int DATA_W     = 32;
  localparam int PROG_WORDS = 4;
  localparam int DISK_BASE  = 8;
  localparam int TIMEOUT    = 5;
  localparam int NO_ACK     = 1000;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } exp_wr_t;

  logic clock;
  logic reset_n;
  logic start;
  logic bios_sel;
  logic busy;
  logic done;
  logic error;

  logic              resp_ack;
  logic              stray_ack;
  logic [DATA_W-1:0] resp_data;

  int                check_cnt;
  int                pass_cnt;
  int                writes_seen;
  int                delays [PROG_WORDS];
  logic [DATA_W-1:0] disk_mem [64];
  exp_wr_t           wr_q [$];
  logic [ADDR_W-1:0] addr_q [$];

  boot_loader_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  assign bus.disk_rd_ack  = resp_ack | stray_ack;
  assign bus.disk_rd_data = resp_data;

  boot_loader_ctrl #(
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .PROG_WORDS (PROG_WORDS),
    .DISK_BASE  (DISK_BASE),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .start    (start),
    .bus      (bus),
    .bios_sel (bios_sel),
    .busy     (busy),
    .done     (done),
    .error    (error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    check_cnt++;
    if (actual === expected) begin
      pass_cnt++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Disk model: acks the request after the planned number of idle cycles.
  int resp_wait;
  int resp_idx;
  always @(negedge clock) begin
    resp_ack = 1'b0;
    if (bus.disk_rd_req) begin
      resp_idx = int'(bus.disk_addr) - DISK_BASE;
      if (resp_idx >= 0 && resp_idx < PROG_WORDS && resp_wait == delays[resp_idx]) begin
        resp_ack  = 1'b1;
        resp_data = disk_mem[bus.disk_addr[5:0]];
      end
      resp_wait++;
    end else begin
      resp_wait = 0;
    end
  end

  // Monitor: every write and every new disk request must match the scoreboard.
  logic              mon_prev_req;
  logic [ADDR_W-1:0] mon_prev_addr;
  exp_wr_t           mon_e;
  always @(negedge clock) begin
    if (reset_n) begin
      if (bus.imem_we) begin
        checkOutput("write expected", 64'(wr_q.size() != 0), 64'(1));
        if (wr_q.size() != 0) begin
          mon_e = wr_q.pop_front();
          checkOutput("imem_addr", 64'(bus.imem_addr), 64'(mon_e.addr));
          checkOutput("imem_wdata", 64'(bus.imem_wdata), 64'(mon_e.data));
        end
        writes_seen++;
      end
      if (bus.disk_rd_req && !mon_prev_req) begin
        checkOutput("request expected", 64'(addr_q.size() != 0), 64'(1));
        if (addr_q.size() != 0) begin
          checkOutput("disk_addr", 64'(bus.disk_addr), 64'(addr_q.pop_front()));
        end
      end
      if (bus.disk_rd_req && mon_prev_req) begin
        checkOutput("disk_addr stable", 64'(bus.disk_addr), 64'(mon_prev_addr));
      end
      mon_prev_req  = bus.disk_rd_req;
      mon_prev_addr = bus.disk_addr;
    end else begin
      mon_prev_req = 1'b0;
    end
  end

  // Reference model: a word costs (delay+2) cycles, a word whose delay reaches
  // TIMEOUT costs TIMEOUT cycles and aborts; the flag appears one cycle later.
  task automatic applyStimulus(input bit poke_busy);
    int fail_word;
    int exp_cycles;
    int n;
    fail_word  = -1;
    exp_cycles = 1;
    for (int j = 0; j < PROG_WORDS; j++) begin
      if (fail_word < 0) begin
        addr_q.push_back(ADDR_W'(DISK_BASE + j));
        if (delays[j] >= TIMEOUT) begin
          fail_word  = j;
          exp_cycles += TIMEOUT;
        end else begin
          exp_cycles += delays[j] + 2;
          wr_q.push_back('{addr: ADDR_W'(j), data: disk_mem[DISK_BASE + j]});
        end
      end
    end
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    n = 0;
    while (n < 400) begin
      @(posedge clock);
      #1;
      n++;
      if (done || error) break;
      start = poke_busy && (n <= exp_cycles - 3) && ($urandom_range(0, 2) == 0);
    end
    start = 1'b0;
    checkOutput("cycles to done/error", 64'(n), 64'(exp_cycles));
    checkOutput("done", 64'(done), 64'(fail_word < 0));
    checkOutput("error", 64'(error), 64'(fail_word >= 0));
    checkOutput("bios_sel", 64'(bios_sel), 64'(fail_word >= 0));
    checkOutput("busy after finish", 64'(busy), 64'(0));
    repeat (2) @(posedge clock);
    #1;
    checkOutput("writes outstanding", 64'(wr_q.size()), 64'(0));
    checkOutput("flag held", 64'(done || error), 64'(1));
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, " disk_rd_req"}, 64'(bus.disk_rd_req), 64'(0));
    checkOutput({tag, " imem_we"}, 64'(bus.imem_we), 64'(0));
    checkOutput({tag, " busy"}, 64'(busy), 64'(0));
    checkOutput({tag, " done"}, 64'(done), 64'(0));
    checkOutput({tag, " error"}, 64'(error), 64'(0));
    checkOutput({tag, " bios_sel"}, 64'(bios_sel), 64'(1));
    checkOutput({tag, " disk_addr"}, 64'(bus.disk_addr), 64'(0));
    checkOutput({tag, " imem_addr"}, 64'(bus.imem_addr), 64'(0));
    checkOutput({tag, " imem_wdata"}, 64'(bus.imem_wdata), 64'(0));
  endtask

  task automatic setDelays(input int d);
    for (int j = 0; j < PROG_WORDS; j++) delays[j] = d;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int base;
    int n;
    check_cnt   = 0;
    pass_cnt    = 0;
    writes_seen = 0;
    resp_wait   = 0;
    resp_ack    = 1'b0;
    stray_ack   = 1'b0;
    resp_data   = '0;
    start       = 1'b0;
    reset_n     = 1'b0;
    for (int i = 0; i < 64; i++) disk_mem[i] = DATA_W'(32'hA0 + i);
    setDelays(0);

    #23;
    checkResetValues("reset");
    @(negedge clock);
    reset_n = 1'b1;

    $display("[TB] idle with stray acks");
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      stray_ack = ($urandom_range(0, 1) == 1);
    end
    @(negedge clock);
    stray_ack = 1'b0;
    @(posedge clock);
    #1;
    checkResetValues("idle");

    $display("[TB] zero-wait copy");
    applyStimulus(1'b0);

    $display("[TB] three-cycle ack delay");
    setDelays(3);
    applyStimulus(1'b0);

    $display("[TB] no ack, then recovery");
    setDelays(NO_ACK);
    applyStimulus(1'b0);
    setDelays(0);
    applyStimulus(1'b0);

    $display("[TB] ack on final allowed wait cycle, start pokes while busy");
    setDelays(TIMEOUT - 1);
    applyStimulus(1'b1);

    $display("[TB] reset between words");
    setDelays(0);
    for (int j = 0; j < PROG_WORDS; j++) begin
      addr_q.push_back(ADDR_W'(DISK_BASE + j));
      wr_q.push_back('{addr: ADDR_W'(j), data: disk_mem[DISK_BASE + j]});
    end
    base  = writes_seen;
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    n = 0;
    while (writes_seen < base + 2 && n < 100) begin
      @(posedge clock);
      #1;
      n++;
    end
    checkOutput("words before reset", 64'(writes_seen - base), 64'(2));
    #1;
    reset_n = 1'b0;
    #1;
    checkResetValues("mid-copy reset");
    wr_q.delete();
    addr_q.delete();
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    applyStimulus(1'b0);

    $display("[TB] randomized copies");
    for (int r = 0; r < 8; r++) begin
      for (int i = DISK_BASE; i < DISK_BASE + PROG_WORDS; i++) disk_mem[i] = $urandom;
      for (int j = 0; j < PROG_WORDS; j++) delays[j] = $urandom_range(0, TIMEOUT - 1);
      if ($urandom_range(0, 4) == 0) delays[$urandom_range(0, PROG_WORDS - 1)] = NO_ACK;
      applyStimulus(1'b1);
    end

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
